anim_frame_sequencer: RTL and testbench

Parametrised draw-and-animate sequencer for the VGA path. It replaces hand-coded per-frame title/choose states with one FSM. On start it cycles through NUM_FRAMES ROM images. For each frame it raster-scans a W x H region at a latched origin, emitting one plotted pixel per clock, then dwells for a programmable time before moving to the next frame. It exits cleanly on userCont. It sits between the top-level game controller and the x/y/colour datapath feeding the VGA adapter.

---
 rtl/anim_frame_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_anim_frame_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/anim_frame_sequencer.sv
// anim_frame_sequencer: cycles through NUM_FRAMES ROM images. For each frame it
// raster-scans a SCREEN_W x SCREEN_H region at a latched origin, plotting one
// pixel per clock, then dwells DWELL_CYCLES before moving to the next frame.
// A userCont request is honoured only after the current frame is complete.
//
// Optional feature macro: CLEAR_BLACK_EN -- when defined, every start first
// scans the region once in black (CLEAR) before frame 0 is drawn.
//
// Ports:
//   clk, stateReset     clock (rising edge), asynchronous active-low reset
//   start               begin animation (sampled in IDLE only)
//   userCont            level request to exit after the current frame
//   xOrigin, yOrigin    region top-left, latched when a scan starts
//   x, y                pixel coordinate (origin + scan counters, modulo width)
//   romAddr             linear pixel address within the frame
//   memorySel           current frame index for the colour ROM mux
//   plot, black         pixel write enable, force-black colour
//   busy                high outside IDLE
//   frameDone, done     last-pixel pulse, exit pulse
module anim_frame_sequencer #(
    parameter int unsigned SCREEN_W     = 160,
    parameter int unsigned SCREEN_H     = 120,
    parameter int unsigned NUM_FRAMES   = 3,
    parameter int unsigned DWELL_CYCLES = 12500000,
    parameter int unsigned X_W          = 8,
    parameter int unsigned Y_W          = 7,
    parameter int unsigned ADDR_W       = 15,
    parameter int unsigned FRAME_W      = 5
) (
    input  logic               clk,
    input  logic               stateReset,
    input  logic               start,
    input  logic               userCont,
    input  logic [X_W-1:0]     xOrigin,
    input  logic [Y_W-1:0]     yOrigin,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [ADDR_W-1:0]  romAddr,
    output logic [FRAME_W-1:0] memorySel,
    output logic               plot,
    output logic               black,
    output logic               busy,
    output logic               frameDone,
    output logic               done
);

    localparam int unsigned XC_W = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
    localparam int unsigned YC_W = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;
    localparam int unsigned DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    localparam logic [XC_W-1:0]    X_LAST     = XC_W'(SCREEN_W - 1);
    localparam logic [YC_W-1:0]    Y_LAST     = YC_W'(SCREEN_H - 1);
    localparam logic [DW_W-1:0]    DW_LAST    = DW_W'(DWELL_CYCLES - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAW,
        S_HOLD,
`ifdef CLEAR_BLACK_EN
        S_CLEAR,
`endif
        S_EXIT
    } state_t;

    state_t             state_q, state_d;
    logic [XC_W-1:0]    xcnt_q, xcnt_d;
    logic [YC_W-1:0]    ycnt_q, ycnt_d;
    logic [DW_W-1:0]    dwell_q, dwell_d;
    logic [X_W-1:0]     xo_q, xo_d;
    logic [Y_W-1:0]     yo_q, yo_d;
    logic               pend_q, pend_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [FRAME_W-1:0] sel_d;
    logic [X_W-1:0]     x_d;
    logic [Y_W-1:0]     y_d;
    logic               plot_d, black_d, busy_d, frame_done_d, done_d;
    logic               last_px;

    // Next-state, counters and next output values; outputs flop from these.
    always_comb begin
        state_d = state_q;
        xcnt_d  = xcnt_q;
        ycnt_d  = ycnt_q;
        dwell_d = dwell_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        pend_d  = pend_q;
        addr_d  = romAddr;
        sel_d   = memorySel;
        last_px = (xcnt_q == X_LAST) && (ycnt_q == Y_LAST);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_d  = '0;
                    xo_d   = xOrigin;
                    yo_d   = yOrigin;
                    xcnt_d = '0;
                    ycnt_d = '0;
                    addr_d = '0;
`ifdef CLEAR_BLACK_EN
                    state_d = S_CLEAR;
`else
                    state_d = S_LOAD;
`endif
                end
            end
            S_LOAD: begin
                xo_d    = xOrigin;
                yo_d    = yOrigin;
                xcnt_d  = '0;
                ycnt_d  = '0;
                addr_d  = '0;
                dwell_d = '0;
                state_d = S_DRAW;
            end
`ifdef CLEAR_BLACK_EN
            S_CLEAR: begin
                if (userCont) pend_d = 1'b1;
                if (last_px) begin
                    state_d = S_LOAD;
                end else begin
                    addr_d = romAddr + ADDR_W'(1);
                    if (xcnt_q == X_LAST) begin
                        xcnt_d = '0;
                        ycnt_d = ycnt_q + YC_W'(1);
                    end else begin
                        xcnt_d = xcnt_q + XC_W'(1);
                    end
                end
            end
`endif
            S_DRAW: begin
                // Exit is deferred so a frame is never left half drawn.
                if (userCont) pend_d = 1'b1;
                if (last_px) begin
                    state_d = S_HOLD;
                end else begin
                    addr_d = romAddr + ADDR_W'(1);
                    if (xcnt_q == X_LAST) begin
                        xcnt_d = '0;
                        ycnt_d = ycnt_q + YC_W'(1);
                    end else begin
                        xcnt_d = xcnt_q + XC_W'(1);
                    end
                end
            end
            S_HOLD: begin
                // Exit takes priority over the dwell terminal count.
                if (pend_q || userCont) begin
                    state_d = S_EXIT;
                end else if (dwell_q == DW_LAST) begin
                    sel_d   = (memorySel == FRAME_LAST) ? '0 : memorySel + FRAME_W'(1);
                    state_d = S_LOAD;
                end else begin
                    dwell_d = dwell_q + DW_W'(1);
                end
            end
            S_EXIT: begin
                pend_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        plot_d       = (state_d == S_DRAW);
        black_d      = 1'b0;
`ifdef CLEAR_BLACK_EN
        plot_d       = plot_d || (state_d == S_CLEAR);
        black_d      = (state_d == S_CLEAR);
`endif
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_EXIT);
        frame_done_d = (state_d == S_DRAW) && (xcnt_d == X_LAST) && (ycnt_d == Y_LAST);
        x_d          = xo_d + X_W'(xcnt_d);
        y_d          = yo_d + Y_W'(ycnt_d);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge stateReset) begin
        if (!stateReset) begin
            state_q   <= S_IDLE;
            xcnt_q    <= '0;
            ycnt_q    <= '0;
            dwell_q   <= '0;
            xo_q      <= '0;
            yo_q      <= '0;
            pend_q    <= 1'b0;
            romAddr   <= '0;
            memorySel <= '0;
            x         <= '0;
            y         <= '0;
            plot      <= 1'b0;
            black     <= 1'b0;
            busy      <= 1'b0;
            frameDone <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            xcnt_q    <= xcnt_d;
            ycnt_q    <= ycnt_d;
            dwell_q   <= dwell_d;
            xo_q      <= xo_d;
            yo_q      <= yo_d;
            pend_q    <= pend_d;
            romAddr   <= addr_d;
            memorySel <= sel_d;
            x         <= x_d;
            y         <= y_d;
            plot      <= plot_d;
            black     <= black_d;
            busy      <= busy_d;
            frameDone <= frame_done_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_anim_frame_sequencer.sv
// Bench for anim_frame_sequencer with a 4x2 region, 3 frames, dwell 5.
// Expected outputs come from a cycle-index model: given the number of cycles
// since start was sampled, the phase, pixel and frame follow by division.
module tb_anim_frame_sequencer;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int F  = 3;
    localparam int D  = 5;
    localparam int WH = W * H;
    localparam int P  = 1 + WH + D;
`ifdef CLEAR_BLACK_EN
    localparam int CLR = WH;
`else
    localparam int CLR = 0;
`endif

    localparam int PH_IDLE  = 0;
    localparam int PH_CLEAR = 1;
    localparam int PH_LOAD  = 2;
    localparam int PH_DRAW  = 3;
    localparam int PH_HOLD  = 4;
    localparam int PH_EXIT  = 5;

    logic        clk = 1'b0;
    logic        stateReset;
    logic        start;
    logic        userCont;
    logic [7:0]  xOrigin;
    logic [6:0]  yOrigin;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [14:0] romAddr;
    logic [4:0]  memorySel;
    logic        plot, black, busy, frameDone, done;

    int n_cmp = 0;
    int n_bad = 0;
    int held_sel = 0;

    typedef struct {
        int ph;
        int sel;
        int px;
    } exp_t;

    anim_frame_sequencer #(
        .SCREEN_W(W), .SCREEN_H(H), .NUM_FRAMES(F), .DWELL_CYCLES(D),
        .X_W(8), .Y_W(7), .ADDR_W(15), .FRAME_W(5)
    ) dut (
        .clk(clk), .stateReset(stateReset), .start(start), .userCont(userCont),
        .xOrigin(xOrigin), .yOrigin(yOrigin), .x(x), .y(y), .romAddr(romAddr),
        .memorySel(memorySel), .plot(plot), .black(black), .busy(busy),
        .frameDone(frameDone), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before timeout");
        $fatal(1, "timeout");
    end

    // Frame index shown while in cycle k (k=1 is the cycle after start is sampled).
    function automatic int sel_at(input int k);
        if (k <= CLR) return 0;
        return ((k - CLR - 1) / P) % F;
    endfunction

    // Cycle index of EXIT for a one-cycle userCont seen at the end of cycle uc; 0 = ignored.
    function automatic int exit_for(input int uc);
        int kk, n, kp;
        if (uc <= CLR) return CLR + WH + 3;
        kk = uc - CLR;
        n  = (kk - 1) / P;
        kp = (kk - 1) % P;
        if (kp == 0) return 0;
        if (kp <= WH) return CLR + n * P + WH + 3;
        return uc + 1;
    endfunction

    function automatic exp_t model(input int k, input int ex, input int hsel);
        exp_t e;
        int kp;
        e.px = 0;
        if (k <= 0) begin
            e.ph = PH_IDLE; e.sel = hsel;
        end else if (ex > 0 && k > ex) begin
            e.ph = PH_IDLE; e.sel = sel_at(ex - 1);
        end else if (ex > 0 && k == ex) begin
            e.ph = PH_EXIT; e.sel = sel_at(ex - 1);
        end else if (k <= CLR) begin
            e.ph = PH_CLEAR; e.sel = 0; e.px = k - 1;
        end else begin
            kp = (k - CLR - 1) % P;
            e.sel = sel_at(k);
            if (kp == 0) e.ph = PH_LOAD;
            else if (kp <= WH) begin e.ph = PH_DRAW; e.px = kp - 1; end
            else e.ph = PH_HOLD;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_state(input exp_t e, input int ox, input int oy);
        bit isplot;
        isplot = (e.ph == PH_DRAW) || (e.ph == PH_CLEAR);
        chk("plot", 32'(plot), 32'(isplot));
        chk("black", 32'(black), 32'(e.ph == PH_CLEAR));
        chk("busy", 32'(busy), 32'(e.ph != PH_IDLE));
        chk("done", 32'(done), 32'(e.ph == PH_EXIT));
        chk("frameDone", 32'(frameDone), 32'((e.ph == PH_DRAW) && (e.px == WH - 1)));
        chk("memorySel", 32'(memorySel), e.sel);
        if (isplot) begin
            chk("x", 32'(x), (ox + e.px % W) % 256);
            chk("y", 32'(y), (oy + e.px / W) % 128);
            chk("romAddr", 32'(romAddr), e.px);
        end
    endtask

    task automatic check_zero();
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_romAddr", 32'(romAddr), 0);
        chk("rst_memorySel", 32'(memorySel), 0);
        chk("rst_plot", 32'(plot), 0);
        chk("rst_black", 32'(black), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frameDone", 32'(frameDone), 0);
        chk("rst_done", 32'(done), 0);
    endtask

    // One animation run: idle noise, start pulse, then cycle-by-cycle checks.
    task automatic run_anim(input int pre, input int ox, input int oy, input int uc, input int tail);
        int ex;
        int last;
        exp_t e;
        ex   = exit_for(uc);
        last = (ex > 0) ? ex + tail : uc + tail;
        xOrigin = 8'(ox);
        yOrigin = 7'(oy);
        repeat (pre) begin
            @(negedge clk);
            check_state(model(0, 0, held_sel), ox, oy);
            start = 1'b0;
            userCont = 1'($urandom % 2);
        end
        @(negedge clk);
        check_state(model(0, 0, held_sel), ox, oy);
        userCont = 1'b0;
        start = 1'b1;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            e = model(k, ex, held_sel);
            check_state(e, ox, oy);
            start = (e.ph != PH_IDLE) ? 1'($urandom % 2) : 1'b0;
            userCont = (k == uc);
        end
        start = 1'b0;
        userCont = 1'b0;
        if (ex > 0) held_sel = sel_at(ex - 1);
    endtask

    initial begin
        int uc;
        stateReset = 1'b0;
        start = 1'b0;
        userCont = 1'b0;
        xOrigin = '0;
        yOrigin = '0;
        #3;
        check_zero();
        @(negedge clk);
        stateReset = 1'b1;

        // Four full periods (frames 0,1,2,0), exit requested mid-draw of the fifth.
        run_anim(2, 10, 20, CLR + 4 * P + 4, 3);
        // userCont on the third pixel: frame completes, exit on first hold cycle.
        run_anim(1, 10, 20, CLR + 4, 2);
        // userCont coincides with dwell terminal count; coordinates wrap.
        run_anim(1, 254, 127, CLR + 2 * P, 2);

        for (int r = 0; r < 6; r++) begin
            uc = CLR + int'($urandom_range(1, 3 * P));
            if (exit_for(uc) == 0) uc++;
            run_anim(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 127)), uc, int'($urandom_range(1, 3)));
        end

        // Asynchronous reset in the middle of a draw.
        xOrigin = 8'd5;
        yOrigin = 7'd6;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            check_state(model(k, 0, held_sel), 5, 6);
        end
        #2;
        stateReset = 1'b0;
        #1;
        check_zero();
        held_sel = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stateReset = 1'b1;
        userCont = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_state(model(0, 0, held_sel), 5, 6);
        end
        userCont = 1'b0;
        run_anim(1, 5, 6, CLR + 3, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
